// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
package multicycle_pkg;

    // Sequencer states; IDLE must stay at zero so a cleared register reads IDLE.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12,
        ILLEGAL = 4'd13
    } state_t;

    // Supported primary opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation select.
    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010
    } alu_op_t;

    // ALU B operand select.
    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    // PC source select.
    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // Complete set of datapath controls driven each cycle.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        pc_src_t    pc_src;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
    } ctrl_t;

    // State following DECODE for a given opcode; unknown opcodes trap.
    function automatic state_t dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = MEMADR;
            OP_RTYPE:     nxt = EXEC;
            OP_BEQ:       nxt = BRANCH;
            OP_ADDI:      nxt = ADDIEX;
            OP_J:         nxt = JUMP;
            default:      nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control decode: current state (plus mem_ready in the
// memory-wait states) to every datapath select and strobe.
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Everything defaults to 0; each state raises only what it needs.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                // Only latch IR / advance PC when the read data is actually there.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                // Branch target precomputed into ALUOut while opcode is decoded.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.retire     = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
                // The store completes (and retires) only in the ready cycle.
                ctrl.retire  = mem_ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
                ctrl.retire   = 1'b1;
            end
            default: begin
                // IDLE and ILLEGAL drive nothing.
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: state register, next-state logic,
// retired-instruction counter and sticky illegal-opcode flag.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal,
    output logic [3:0]       state_o
);

    state_t           state_reg;
    state_t           state_next;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] count_reg;
    logic             illegal_reg;

    // State register; reset drops straight to IDLE so no strobe survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = mem_ready ? DECODE : FETCH;
            DECODE:  state_next = dispatch(opcode);
            MEMADR:  state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_next = FETCH;
            MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
            EXEC:    state_next = ALUWB;
            ALUWB:   state_next = FETCH;
            BRANCH:  state_next = FETCH;
            ADDIEX:  state_next = ADDIWB;
            ADDIWB:  state_next = FETCH;
            JUMP:    state_next = FETCH;
            ILLEGAL: state_next = ILLEGAL;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs are a pure function of state (and mem_ready).
    multicycle_ctrl_decode u_decode (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (ctrl.retire) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Sticky flag, raised on entry to the trap state; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (state_next == ILLEGAL) begin
            illegal_reg <= 1'b1;
        end
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign retire        = ctrl.retire;
    assign instr_count   = count_reg;
    assign illegal       = illegal_reg;
    assign state_o       = state_reg;

endmodule
